// File: rtl/axis_sync_fifo.sv
// rtl/axis_sync_fifo.sv - single-clock AXI-Stream FIFO with optional store-and-forward packet mode
// First-word fall-through from a register-file array; all status flags come from registered counts.

module axis_sync_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 32,
    parameter int TUSER_WIDTH = 1,
    parameter int HAS_TID     = 0,
    parameter int HAS_TDEST   = 0,
    parameter int HAS_TUSER   = 0,
    parameter int PACKET_MODE = 0,
    parameter int AF_THRESH   = FIFO_DEPTH - 2,
    parameter int AE_THRESH   = 2,
    localparam int TKEEP_WIDTH = DATA_WIDTH / 8,
    localparam int PTR_WIDTH   = $clog2(FIFO_DEPTH)
) (
    input  logic                   axis_aclk,
    input  logic                   axis_resetn,

    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [TKEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                   s_axis_tlast,
    input  logic [2:0]             s_axis_tid,
    input  logic [0:0]             s_axis_tdest,
    input  logic [TUSER_WIDTH-1:0] s_axis_tuser,

    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic [TKEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic [2:0]             m_axis_tid,
    output logic [0:0]             m_axis_tdest,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,

    output logic [PTR_WIDTH:0]     fill_level,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [PTR_WIDTH:0]     pkt_count
);

    localparam int CNT_W   = PTR_WIDTH + 1;
    localparam int ENTRY_W = DATA_WIDTH + TKEEP_WIDTH + 1 + 3 + 1 + TUSER_WIDTH;

    logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];

    logic [CNT_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       fill_level_q, fill_level_d;
    logic [CNT_W-1:0]       pkt_count_q, pkt_count_d;
    logic                   s_tready_q, s_tready_d;
    logic                   cut_through_q, cut_through_d;

    logic                   full, empty, m_tvalid;
    logic                   wr_en, rd_en, wr_last, rd_last;
    logic [2:0]             tid_in, tid_raw;
    logic [0:0]             tdest_in, tdest_raw;
    logic [TUSER_WIDTH-1:0] tuser_in, tuser_raw;
    logic [ENTRY_W-1:0]     wr_entry, rd_entry;
    logic [DATA_WIDTH-1:0]  tdata_raw;
    logic [TKEEP_WIDTH-1:0] tkeep_raw;
    logic                   tlast_raw;

    // Disabled sideband fields are zeroed on the way in so their storage bits are constant.
    assign tid_in   = (HAS_TID   != 0) ? s_axis_tid   : '0;
    assign tdest_in = (HAS_TDEST != 0) ? s_axis_tdest : '0;
    assign tuser_in = (HAS_TUSER != 0) ? s_axis_tuser : '0;
    assign wr_entry = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, tid_in, tdest_in, tuser_in};

    assign rd_entry = mem_q[rd_ptr_q[PTR_WIDTH-1:0]];
    assign {tdata_raw, tkeep_raw, tlast_raw, tid_raw, tdest_raw, tuser_raw} = rd_entry;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]) &&
                   (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]);

    // In packet mode a full FIFO with no complete packet latches cut-through so an
    // over-long packet keeps draining instead of deadlocking.
    assign m_tvalid = (PACKET_MODE != 0)
                    ? ((fill_level_q != '0) && ((pkt_count_q != '0) || full || cut_through_q))
                    : (fill_level_q != '0);

    assign wr_en   = s_axis_tvalid && s_tready_q && !full;
    assign rd_en   = m_tvalid && m_axis_tready && !empty;
    assign wr_last = wr_en && s_axis_tlast;
    assign rd_last = rd_en && tlast_raw;

    always_comb begin
        wr_ptr_d      = wr_ptr_q + CNT_W'(wr_en);
        rd_ptr_d      = rd_ptr_q + CNT_W'(rd_en);

        fill_level_d  = fill_level_q;
        case ({wr_en, rd_en})
            2'b10:   fill_level_d = fill_level_q + 1'b1;
            2'b01:   fill_level_d = fill_level_q - 1'b1;
            default: fill_level_d = fill_level_q;
        endcase

        pkt_count_d   = pkt_count_q;
        case ({wr_last, rd_last})
            2'b10:   pkt_count_d = pkt_count_q + 1'b1;
            2'b01:   pkt_count_d = pkt_count_q - 1'b1;
            default: pkt_count_d = pkt_count_q;
        endcase

        s_tready_d    = (fill_level_d != CNT_W'(FIFO_DEPTH));

        cut_through_d = 1'b0;
        if (PACKET_MODE != 0) begin
            cut_through_d = (cut_through_q || (full && (pkt_count_q == '0))) &&
                            !(wr_last || rd_last);
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fill_level_q  <= '0;
            pkt_count_q   <= '0;
            s_tready_q    <= 1'b0;
            cut_through_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fill_level_q  <= fill_level_d;
            pkt_count_q   <= pkt_count_d;
            s_tready_q    <= s_tready_d;
            cut_through_q <= cut_through_d;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[PTR_WIDTH-1:0]] <= wr_entry;
        end
    end

    assign s_axis_tready = s_tready_q;
    assign m_axis_tvalid = m_tvalid;
    assign m_axis_tdata  = tdata_raw;
    assign m_axis_tkeep  = tkeep_raw;
    assign m_axis_tlast  = tlast_raw;
    assign m_axis_tid    = (HAS_TID   != 0) ? tid_raw   : '0;
    assign m_axis_tdest  = (HAS_TDEST != 0) ? tdest_raw : '0;
    assign m_axis_tuser  = (HAS_TUSER != 0) ? tuser_raw : '0;

    assign fill_level    = fill_level_q;
    assign pkt_count     = pkt_count_q;
    assign almost_full   = (fill_level_q >= CNT_W'(AF_THRESH));
    assign almost_empty  = (fill_level_q <= CNT_W'(AE_THRESH));

endmodule

// File: tb/tb_axis_sync_fifo.sv
// tb/tb_axis_sync_fifo.sv - scoreboard bench for axis_sync_fifo in streaming and packet modes
// Instance a: depth 8, all sideband stored; instance b: depth 8, packet mode, sideband disabled.

module tb_axis_sync_fifo;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_s_tvalid, a_s_tready, a_s_tlast, a_m_tvalid, a_m_tready, a_m_tlast;
    logic [31:0] a_s_tdata, a_m_tdata;
    logic [3:0]  a_s_tkeep, a_m_tkeep, a_fill, a_pkt;
    logic [2:0]  a_s_tid, a_m_tid;
    logic [0:0]  a_s_tdest, a_m_tdest, a_s_tuser, a_m_tuser;
    logic        a_af, a_ae;

    logic        b_s_tvalid, b_s_tready, b_s_tlast, b_m_tvalid, b_m_tready, b_m_tlast;
    logic [31:0] b_s_tdata, b_m_tdata;
    logic [3:0]  b_s_tkeep, b_m_tkeep, b_fill, b_pkt;
    logic [2:0]  b_s_tid, b_m_tid;
    logic [0:0]  b_s_tdest, b_m_tdest, b_s_tuser, b_m_tuser;
    logic        b_af, b_ae;

    int vectors = 0;
    int miscompares = 0;
    int b_pops = 0;
    logic [41:0] a_q[$];
    logic [41:0] b_q[$];

    axis_sync_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .TUSER_WIDTH(1), .HAS_TID(1), .HAS_TDEST(1),
                     .HAS_TUSER(1), .PACKET_MODE(0)) dut_a (
        .axis_aclk(clk), .axis_resetn(rst_n),
        .s_axis_tvalid(a_s_tvalid), .s_axis_tready(a_s_tready), .s_axis_tdata(a_s_tdata),
        .s_axis_tkeep(a_s_tkeep), .s_axis_tlast(a_s_tlast), .s_axis_tid(a_s_tid),
        .s_axis_tdest(a_s_tdest), .s_axis_tuser(a_s_tuser),
        .m_axis_tvalid(a_m_tvalid), .m_axis_tready(a_m_tready), .m_axis_tdata(a_m_tdata),
        .m_axis_tkeep(a_m_tkeep), .m_axis_tlast(a_m_tlast), .m_axis_tid(a_m_tid),
        .m_axis_tdest(a_m_tdest), .m_axis_tuser(a_m_tuser),
        .fill_level(a_fill), .almost_full(a_af), .almost_empty(a_ae), .pkt_count(a_pkt)
    );

    axis_sync_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .TUSER_WIDTH(1), .HAS_TID(0), .HAS_TDEST(0),
                     .HAS_TUSER(0), .PACKET_MODE(1)) dut_b (
        .axis_aclk(clk), .axis_resetn(rst_n),
        .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready), .s_axis_tdata(b_s_tdata),
        .s_axis_tkeep(b_s_tkeep), .s_axis_tlast(b_s_tlast), .s_axis_tid(b_s_tid),
        .s_axis_tdest(b_s_tdest), .s_axis_tuser(b_s_tuser),
        .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready), .m_axis_tdata(b_m_tdata),
        .m_axis_tkeep(b_m_tkeep), .m_axis_tlast(b_m_tlast), .m_axis_tid(b_m_tid),
        .m_axis_tdest(b_m_tdest), .m_axis_tuser(b_m_tuser),
        .fill_level(b_fill), .almost_full(b_af), .almost_empty(b_ae), .pkt_count(b_pkt)
    );

    // Scoreboard monitors sample mid-cycle, when the coming edge's handshakes are settled.
    logic        a_hold = 1'b0;
    logic [41:0] a_prev, a_cur, a_exp, b_cur, b_exp;

    initial begin
        forever begin
            @(negedge clk);
            a_cur = {a_m_tdata, a_m_tkeep, a_m_tlast, a_m_tid, a_m_tdest, a_m_tuser};
            if (!rst_n) begin
                a_hold = 1'b0;
            end else begin
                if (a_hold) begin
                    vectors++;
                    if (a_m_tvalid !== 1'b1 || a_cur !== a_prev) begin
                        miscompares++;
                        $display("FAIL a_hold_stable: got valid=%b beat=%h, need valid=1 beat=%h",
                                 a_m_tvalid, a_cur, a_prev);
                    end
                end
                if (a_m_tvalid && a_m_tready) begin
                    vectors++;
                    if (a_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL a_unexpected_beat: got %h, need no beat", a_cur);
                    end else begin
                        a_exp = a_q.pop_front();
                        if (a_cur !== a_exp) begin
                            miscompares++;
                            $display("FAIL a_beat: got %h, need %h", a_cur, a_exp);
                        end
                    end
                end
                if (a_s_tvalid && a_s_tready)
                    a_q.push_back({a_s_tdata, a_s_tkeep, a_s_tlast, a_s_tid, a_s_tdest, a_s_tuser});
                a_hold = a_m_tvalid && !a_m_tready;
                a_prev = a_cur;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            b_cur = {b_m_tdata, b_m_tkeep, b_m_tlast, b_m_tid, b_m_tdest, b_m_tuser};
            if (rst_n) begin
                if (b_m_tvalid && b_m_tready) begin
                    vectors++;
                    b_pops++;
                    if (b_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL b_unexpected_beat: got %h, need no beat", b_cur);
                    end else begin
                        b_exp = b_q.pop_front();
                        if (b_cur !== b_exp) begin
                            miscompares++;
                            $display("FAIL b_beat: got %h, need %h", b_cur, b_exp);
                        end
                    end
                end
                if (b_s_tvalid && b_s_tready)
                    b_q.push_back({b_s_tdata, b_s_tkeep, b_s_tlast, 3'b000, 1'b0, 1'b0});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, need completion", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_s_tvalid = 0; a_s_tdata = 0; a_s_tkeep = 0; a_s_tlast = 0;
        a_s_tid = 0; a_s_tdest = 0; a_s_tuser = 0; a_m_tready = 0;
        b_s_tvalid = 0; b_s_tdata = 0; b_s_tkeep = 4'hF; b_s_tlast = 0;
        b_s_tid = 3'h5; b_s_tdest = 1'b1; b_s_tuser = 1'b1; b_m_tready = 0;
        rst_n = 0;
        #22;
        vectors++;
        if ({a_s_tready, a_m_tvalid, a_af, a_ae, a_fill, a_pkt} !== {4'b0001, 4'd0, 4'd0}) begin
            miscompares++;
            $display("FAIL reset_state_a: got tready/tvalid/af/ae=%b%b%b%b fill=%0d pkt=%0d, need 0001 0 0",
                     a_s_tready, a_m_tvalid, a_af, a_ae, a_fill, a_pkt);
        end
        vectors++;
        if ({b_s_tready, b_m_tvalid, b_ae, b_fill} !== {3'b001, 4'd0}) begin
            miscompares++;
            $display("FAIL reset_state_b: got tready/tvalid/ae=%b%b%b fill=%0d, need 001 0",
                     b_s_tready, b_m_tvalid, b_ae, b_fill);
        end
        @(negedge clk);
        #2 rst_n = 1;
        #1;
        vectors++;
        if (a_s_tready !== 1'b0) begin
            miscompares++;
            $display("FAIL tready_before_edge: got %b, need 0", a_s_tready);
        end
        tick();
        vectors++;
        if (a_s_tready !== 1'b1 || b_s_tready !== 1'b1) begin
            miscompares++;
            $display("FAIL tready_after_release: got a=%b b=%b, need 1 1", a_s_tready, b_s_tready);
        end
    endtask

    task automatic test_fill_drain();
        a_m_tready = 0;
        for (int i = 0; i < 8; i++) begin
            a_s_tvalid = 1; a_s_tdata = i; a_s_tkeep = 4'hF ^ i[3:0];
            a_s_tlast = (i == 3 || i == 7); a_s_tid = i[2:0]; a_s_tdest = i[0]; a_s_tuser = ~i[0];
            if (i == 0) begin
                vectors++;
                if (a_m_tvalid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL empty_tvalid: got %b, need 0", a_m_tvalid);
                end
            end
            tick();
            vectors++;
            if (a_fill !== 4'(i + 1) || a_af !== (i + 1 >= 6) || a_ae !== (i + 1 <= 2) ||
                a_m_tvalid !== 1'b1 || a_s_tready !== (i + 1 != 8)) begin
                miscompares++;
                $display("FAIL fill_step%0d: got fill=%0d af=%b ae=%b tvalid=%b tready=%b, need fill=%0d af=%b ae=%b tvalid=1 tready=%b",
                         i, a_fill, a_af, a_ae, a_m_tvalid, a_s_tready, i + 1, (i + 1 >= 6),
                         (i + 1 <= 2), (i + 1 != 8));
            end
        end
        a_s_tvalid = 0;
        vectors++;
        if (a_pkt !== 4'd2) begin
            miscompares++;
            $display("FAIL pkt_count_full: got %0d, need 2", a_pkt);
        end
        a_m_tready = 1;
        repeat (8) tick();
        a_m_tready = 0;
        vectors++;
        if (a_fill !== 4'd0 || a_m_tvalid !== 1'b0 || a_pkt !== 4'd0 || a_ae !== 1'b1 ||
            a_q.size() != 0) begin
            miscompares++;
            $display("FAIL drained: got fill=%0d tvalid=%b pkt=%0d ae=%b left=%0d, need 0 0 0 1 0",
                     a_fill, a_m_tvalid, a_pkt, a_ae, a_q.size());
        end
    endtask

    task automatic test_full_simultaneous();
        a_m_tready = 0;
        for (int i = 0; i < 8; i++) begin
            a_s_tvalid = 1; a_s_tdata = 32'h100 + i; a_s_tkeep = 4'hF; a_s_tlast = 0;
            a_s_tid = 3'h2; a_s_tdest = 1'b0; a_s_tuser = 1'b1;
            tick();
        end
        a_s_tdata = 32'h1FF;
        vectors++;
        if (a_fill !== 4'd8 || a_s_tready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_state: got fill=%0d tready=%b, need 8 0", a_fill, a_s_tready);
        end
        a_m_tready = 1;
        tick();
        a_s_tvalid = 0; a_m_tready = 0;
        vectors++;
        if (a_fill !== 4'd7 || a_s_tready !== 1'b1) begin
            miscompares++;
            $display("FAIL full_read_write: got fill=%0d tready=%b, need 7 1", a_fill, a_s_tready);
        end
        a_m_tready = 1;
        repeat (7) tick();
        a_m_tready = 0;
        vectors++;
        if (a_fill !== 4'd0 || a_q.size() != 0) begin
            miscompares++;
            $display("FAIL full_drain: got fill=%0d left=%0d, need 0 0", a_fill, a_q.size());
        end
    endtask

    task automatic test_back_to_back();
        a_m_tready = 1;
        for (int i = 0; i < 40; i++) begin
            a_s_tvalid = 1; a_s_tdata = 32'h200 + i; a_s_tkeep = i[3:0];
            a_s_tlast = i[0]; a_s_tid = i[4:2]; a_s_tdest = i[1]; a_s_tuser = i[2];
            tick();
            vectors++;
            if (a_fill !== 4'd1) begin
                miscompares++;
                $display("FAIL stream_fill%0d: got %0d, need 1", i, a_fill);
            end
        end
        a_s_tvalid = 0;
        tick();
        a_m_tready = 0;
        vectors++;
        if (a_fill !== 4'd0 || a_pkt !== 4'd0 || a_q.size() != 0) begin
            miscompares++;
            $display("FAIL stream_end: got fill=%0d pkt=%0d left=%0d, need 0 0 0",
                     a_fill, a_pkt, a_q.size());
        end
    endtask

    task automatic test_backpressure();
        int model;
        logic w, r;
        model = 0;
        for (int i = 0; i < 120; i++) begin
            a_s_tvalid = 1'($urandom_range(0, 1)); a_s_tdata = $urandom; a_s_tkeep = 4'($urandom);
            a_s_tlast = 1'($urandom); a_s_tid = 3'($urandom); a_s_tdest = 1'($urandom);
            a_s_tuser = 1'($urandom);
            a_m_tready = ($urandom_range(0, 2) == 0);
            #2;
            w = a_s_tvalid && a_s_tready;
            r = a_m_tvalid && a_m_tready;
            tick();
            model = model + int'(w) - int'(r);
            vectors++;
            if (a_fill !== 4'(model) || a_s_tready !== (model != 8) || a_m_tvalid !== (model != 0)) begin
                miscompares++;
                $display("FAIL bp_step%0d: got fill=%0d tready=%b tvalid=%b, need fill=%0d tready=%b tvalid=%b",
                         i, a_fill, a_s_tready, a_m_tvalid, model, (model != 8), (model != 0));
            end
        end
        a_s_tvalid = 0; a_m_tready = 1;
        for (int i = 0; i < 12 && a_fill != 0; i++) tick();
        a_m_tready = 0;
        vectors++;
        if (a_fill !== 4'd0 || a_q.size() != 0) begin
            miscompares++;
            $display("FAIL bp_drain: got fill=%0d left=%0d, need 0 0", a_fill, a_q.size());
        end
    endtask

    task automatic test_packet();
        b_m_tready = 1;
        for (int i = 0; i < 3; i++) begin
            b_s_tvalid = 1; b_s_tdata = 32'h400 + i; b_s_tlast = (i == 2);
            tick();
            vectors++;
            if (b_m_tvalid !== (i == 2) || b_pkt !== 4'(i == 2)) begin
                miscompares++;
                $display("FAIL pkt_gate%0d: got tvalid=%b pkt=%0d, need %b %0d",
                         i, b_m_tvalid, b_pkt, (i == 2), (i == 2));
            end
        end
        b_s_tvalid = 0; b_s_tlast = 0;
        b_pops = 0;
        tick();
        tick();
        vectors++;
        if (b_pkt !== 4'd1 || b_fill !== 4'd1) begin
            miscompares++;
            $display("FAIL pkt_mid: got pkt=%0d fill=%0d, need 1 1", b_pkt, b_fill);
        end
        tick();
        vectors++;
        if (b_pkt !== 4'd0 || b_fill !== 4'd0 || b_m_tvalid !== 1'b0 || b_pops != 3) begin
            miscompares++;
            $display("FAIL pkt_done: got pkt=%0d fill=%0d tvalid=%b beats=%0d, need 0 0 0 3",
                     b_pkt, b_fill, b_m_tvalid, b_pops);
        end
    endtask

    task automatic test_long_packet();
        int idx, cycles;
        logic acc, seen_full;
        idx = 0; cycles = 0; seen_full = 0;
        b_pops = 0;
        b_m_tready = 1;
        while ((idx < 12 || b_q.size() != 0) && cycles < 200) begin
            if (idx < 12) begin
                b_s_tvalid = 1; b_s_tdata = 32'h300 + idx; b_s_tlast = (idx == 11);
            end else begin
                b_s_tvalid = 0; b_s_tlast = 0;
            end
            #2;
            acc = b_s_tvalid && b_s_tready;
            tick();
            cycles++;
            if (acc) idx++;
            if (!seen_full && b_fill == 4'd8) begin
                seen_full = 1;
                vectors++;
                if (b_m_tvalid !== 1'b1 || idx != 8) begin
                    miscompares++;
                    $display("FAIL long_full: got tvalid=%b stored=%0d, need 1 8", b_m_tvalid, idx);
                end
            end else if (!seen_full) begin
                vectors++;
                if (b_m_tvalid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL long_gate: got tvalid=%b at %0d stored, need 0", b_m_tvalid, idx);
                end
            end
        end
        b_s_tvalid = 0;
        vectors++;
        if (cycles >= 200 || b_pops != 12 || b_fill !== 4'd0 || b_pkt !== 4'd0 || !seen_full) begin
            miscompares++;
            $display("FAIL long_done: got cycles=%0d beats=%0d fill=%0d pkt=%0d full_seen=%b, need <200 12 0 0 1",
                     cycles, b_pops, b_fill, b_pkt, seen_full);
        end
    endtask

    task automatic test_reset_mid_packet();
        a_m_tready = 0; b_m_tready = 0;
        for (int i = 0; i < 5; i++) begin
            a_s_tvalid = 1; a_s_tdata = 32'h500 + i; a_s_tlast = 0;
            b_s_tvalid = 1; b_s_tdata = 32'h600 + i; b_s_tlast = 0;
            tick();
        end
        vectors++;
        if (a_fill !== 4'd5 || b_fill !== 4'd5) begin
            miscompares++;
            $display("FAIL mid_fill: got a=%0d b=%0d, need 5 5", a_fill, b_fill);
        end
        #2 rst_n = 0;
        #1;
        a_s_tvalid = 0; b_s_tvalid = 0;
        a_q.delete(); b_q.delete();
        vectors++;
        if (a_fill !== 4'd0 || a_m_tvalid !== 1'b0 || a_s_tready !== 1'b0 || a_pkt !== 4'd0 ||
            a_ae !== 1'b1 || b_fill !== 4'd0) begin
            miscompares++;
            $display("FAIL mid_reset: got fill=%0d tvalid=%b tready=%b pkt=%0d ae=%b bfill=%0d, need 0 0 0 0 1 0",
                     a_fill, a_m_tvalid, a_s_tready, a_pkt, a_ae, b_fill);
        end
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1;
        a_m_tready = 1; b_m_tready = 1;
        tick();
        vectors++;
        if (a_s_tready !== 1'b1 || b_s_tready !== 1'b1 || a_m_tvalid !== 1'b0 || a_fill !== 4'd0) begin
            miscompares++;
            $display("FAIL mid_release: got tready a=%b b=%b tvalid=%b fill=%0d, need 1 1 0 0",
                     a_s_tready, b_s_tready, a_m_tvalid, a_fill);
        end
        tick();
        a_m_tready = 0; b_m_tready = 0;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_simultaneous();
        test_back_to_back();
        test_backpressure();
        test_packet();
        test_long_packet();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axis_sync_fifo.md
AXIS_SYNC_FIFO -- requirements
Module: axis_sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32: tdata width, multiple of 8; TKEEP_WIDTH = DATA_WIDTH/8.
REQ-002 Parameter FIFO_DEPTH, default 32: entries, power of 2, >= 4; PTR_WIDTH = clog2(FIFO_DEPTH).
REQ-003 Parameter TUSER_WIDTH, default 1: tuser width.
REQ-004 Parameters HAS_TID, HAS_TDEST, HAS_TUSER, default 0 each: 1 = field stored; 0 = field not stored, output tied to 0.
REQ-005 Parameter PACKET_MODE, default 0: 1 = store-and-forward on tlast.
REQ-006 Parameters AF_THRESH, default FIFO_DEPTH-2, and AE_THRESH, default 2: almost-full/almost-empty levels.
REQ-007 axis_aclk  in  1  single clock; all logic on rising edge.
REQ-008 axis_resetn  in  1  asynchronous, active-low reset.
REQ-009 s_axis_tvalid/tdata/tkeep/tlast  in  1/DATA_WIDTH/TKEEP_WIDTH/1  slave beat.
REQ-010 s_axis_tid/tdest/tuser  in  3/1/TUSER_WIDTH  sideband; ignored when the matching HAS_* = 0.
REQ-011 s_axis_tready  out  1  FIFO can accept a beat.
REQ-012 m_axis_tvalid/tdata/tkeep/tlast/tid/tdest/tuser  out  widths as slave side  master beat.
REQ-013 m_axis_tready  in  1  downstream accepts.
REQ-014 fill_level  out  PTR_WIDTH+1  stored beat count, 0..FIFO_DEPTH.
REQ-015 almost_full  out  1  fill_level >= AF_THRESH.
REQ-016 almost_empty  out  1  fill_level <= AE_THRESH.
REQ-017 pkt_count  out  PTR_WIDTH+1  complete packets (tlast beats) stored.

Function
REQ-018 Write occurs on a cycle with s_axis_tvalid & s_axis_tready; read on a cycle with m_axis_tvalid & m_axis_tready.
REQ-019 tdata, tkeep, tlast and the enabled sideband fields shall be stored together per entry and presented unchanged, in write order.
REQ-020 Pointers wr_ptr/rd_ptr shall be PTR_WIDTH+1 bits and wrap modulo 2*FIFO_DEPTH; empty = pointers equal, full = low bits equal and MSBs differ.
REQ-021 fill_level next = fill_level +1 on write only, -1 on read only, unchanged on both or neither; registered.
REQ-022 s_axis_tready shall be registered, equal to (fill_level_next != FIFO_DEPTH); full with simultaneous read shall not accept a write that cycle, tready returns 1 the next cycle.
REQ-023 Data written on cycle N shall be visible on the master side (m_axis_tvalid = 1) at cycle N+1 (one-cycle write-to-read latency, first-word fall-through).
REQ-024 While m_axis_tvalid = 1 and m_axis_tready = 0, all m_axis_* outputs shall hold stable.
REQ-025 PACKET_MODE = 0: m_axis_tvalid = (fill_level != 0).
REQ-026 PACKET_MODE = 1: m_axis_tvalid = (fill_level != 0) & ((pkt_count != 0) | full).
REQ-027 pkt_count next = +1 on write with tlast, -1 on read with tlast, unchanged when both or neither; maintained in both modes.
REQ-028 PACKET_MODE = 1 with full and pkt_count = 0 (packet longer than FIFO_DEPTH): FIFO shall cut through, draining beats until a tlast is stored or read, preventing deadlock.
REQ-029 almost_full and almost_empty shall be combinational from registered fill_level.
REQ-030 Read on an empty FIFO and write on a full FIFO shall never occur; pointers and counts shall not change.

Reset
REQ-031 axis_resetn low shall immediately clear wr_ptr, rd_ptr, fill_level, pkt_count to 0 and s_axis_tready to 0, regardless of clock.
REQ-032 During reset m_axis_tvalid = 0, almost_full = 0 (for AF_THRESH > 0), almost_empty = 1; storage contents need not be cleared.
REQ-033 s_axis_tready shall rise on the first axis_aclk edge after axis_resetn deasserts.
REQ-034 Reset asserted mid-packet shall discard all stored beats; no partial packet shall be output after reset.

Verification (FIFO_DEPTH=8, DATA_WIDTH=32)
REQ-035 Write 0x00..0x07 with m_axis_tready=0 -> fill_level 8, s_axis_tready 0 next cycle, almost_full 1; then drain -> data 0x00..0x07 in order, fill_level 0.
REQ-036 Full FIFO, s_axis_tvalid=1 and m_axis_tready=1 same cycle -> one read, no write, fill_level 7, tready 1 next cycle.
REQ-037 PACKET_MODE=1, write 3-beat packet, tlast on beat 3 -> m_axis_tvalid 0 until cycle after beat 3, then 3 beats out, pkt_count 1 -> 0.
REQ-038 PACKET_MODE=1, 12-beat packet, m_axis_tready=1 -> after 8 stored m_axis_tvalid 1, all 12 beats delivered in order, no deadlock.
REQ-039 Continuous write and read at 1 beat/cycle for 40 beats -> fill_level constant 1, pointers wrap past 15 correctly, no data loss.
REQ-040 axis_resetn low after 5 writes (mid-packet) -> fill_level 0, m_axis_tvalid 0 immediately; s_axis_tready 1 on first edge after release.
